// File: rtl/cluster_link_tx.sv
// cluster_link_tx: captures eight clusters per bunch crossing, buffers the valid ones
// and frames them onto a 16-bit link as one header word plus three cluster/idle words.
`default_nettype none

module cluster_link_tx #(
  parameter int          FIFO_DEPTH = 16,
  parameter int          ADR_MAX    = 1535,
  parameter logic [15:0] IDLE_WORD  = 16'hF7F7
) (
  input  logic                          clock4x,
  input  logic                          reset_n,
  input  logic                          bx_strobe,
  input  logic [13:0]                   cluster0,
  input  logic [13:0]                   cluster1,
  input  logic [13:0]                   cluster2,
  input  logic [13:0]                   cluster3,
  input  logic [13:0]                   cluster4,
  input  logic [13:0]                   cluster5,
  input  logic [13:0]                   cluster6,
  input  logic [13:0]                   cluster7,
  output logic [15:0]                   link_data,
  output logic                          link_k,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   overflow_cnt
);

  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam int             LW      = AW + 1;
  localparam logic [LW-1:0]  DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [10:0]    ADR_LIM = 11'(ADR_MAX);

  logic [1:0]    slot;
  logic [6:0]    frame_num;
  logic          ovf_pending;
  logic          scan_active;
  logic [1:0]    scan_idx;
  logic [13:0]   cap [8];
  logic [13:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [13:0]   c_lo, c_hi, first_data;
  logic          v_lo, v_hi, first_v, second_v, acc1, acc2, pop;
  logic [1:0]    n_wr;
  logic [3:0]    scan_drops, rs_drops, drops;
  logic [16:0]   ovf_sum;

  function automatic logic is_valid(input logic [13:0] c);
    return c[10:0] <= ADR_LIM;
  endfunction

  always_comb begin
    c_lo       = cap[{scan_idx, 1'b0}];
    c_hi       = cap[{scan_idx, 1'b1}];
    v_lo       = scan_active && is_valid(c_lo);
    v_hi       = scan_active && is_valid(c_hi);
    first_v    = v_lo | v_hi;
    second_v   = v_lo & v_hi;
    first_data = v_lo ? c_lo : c_hi;
    // Room is judged on the start-of-cycle level; a same-cycle pop frees nothing.
    acc1       = first_v && (fifo_level < DEPTH_L);
    acc2       = second_v && ((fifo_level + LW'(acc1)) < DEPTH_L);
    n_wr       = 2'(acc1) + 2'(acc2);
    pop        = (slot != 2'd0) && (fifo_level != '0);
    scan_drops = 4'(first_v & ~acc1) + 4'(second_v & ~acc2);
    rs_drops   = '0;
    if (bx_strobe && scan_active) begin
      // Re-strobe abandons every pair after the one being scanned this cycle.
      for (int i = 0; i < 8; i++) begin
        if (((i / 2) > int'(scan_idx)) && is_valid(cap[i])) begin
          rs_drops = rs_drops + 4'd1;
        end
      end
    end
    drops   = scan_drops + rs_drops;
    ovf_sum = {1'b0, overflow_cnt} + {13'b0, drops};
  end

  always_ff @(posedge clock4x) begin
    if (acc1) mem[wr_ptr] <= first_data;
    if (acc2) mem[wr_ptr + AW'(1)] <= c_hi;
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      slot         <= '0;
      frame_num    <= '0;
      ovf_pending  <= 1'b0;
      scan_active  <= 1'b0;
      scan_idx     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      overflow_cnt <= '0;
      link_data    <= '0;
      link_k       <= 1'b0;
      for (int i = 0; i < 8; i++) cap[i] <= '0;
    end else begin
      slot <= slot + 2'd1;
      if (slot == 2'd0) begin
        link_k    <= 1'b1;
        link_data <= {8'hBC, ovf_pending, frame_num};
        frame_num <= frame_num + 7'd1;
      end else if (pop) begin
        link_k    <= 1'b0;
        link_data <= {2'b01, mem[rd_ptr]};
        rd_ptr    <= rd_ptr + AW'(1);
      end else begin
        link_k    <= 1'b1;
        link_data <= IDLE_WORD;
      end

      ovf_pending  <= ((slot == 2'd0) ? 1'b0 : ovf_pending) | (drops != 4'd0);
      overflow_cnt <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
      wr_ptr       <= wr_ptr + AW'(n_wr);
      fifo_level   <= fifo_level + LW'(n_wr) - LW'(pop);

      if (bx_strobe) begin
        cap[0]      <= cluster0;
        cap[1]      <= cluster1;
        cap[2]      <= cluster2;
        cap[3]      <= cluster3;
        cap[4]      <= cluster4;
        cap[5]      <= cluster5;
        cap[6]      <= cluster6;
        cap[7]      <= cluster7;
        scan_idx    <= '0;
        scan_active <= 1'b1;
      end else if (scan_active) begin
        scan_idx <= scan_idx + 2'd1;
        if (scan_idx == 2'd3) scan_active <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cluster_link_tx.sv
// Scoreboard bench for cluster_link_tx: a queue-based reference model predicts every
// link word, level and overflow count; a monitor compares them on the falling edge.
`default_nettype none

module tb_cluster_link_tx;

  localparam int DEPTH   = 16;
  localparam int ADR_LIM = 1535;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        bx_strobe;
  logic [13:0] cl [8];
  logic [15:0] link_data;
  logic        link_k;
  logic [4:0]  fifo_level;
  logic [15:0] overflow_cnt;

  int errors = 0;
  int checks = 0;
  int max_lvl = 0;

  always #5 clk = ~clk;

  cluster_link_tx #(.FIFO_DEPTH(DEPTH), .ADR_MAX(ADR_LIM), .IDLE_WORD(16'hF7F7)) dut (
    .clock4x(clk), .reset_n(reset_n), .bx_strobe(bx_strobe),
    .cluster0(cl[0]), .cluster1(cl[1]), .cluster2(cl[2]), .cluster3(cl[3]),
    .cluster4(cl[4]), .cluster5(cl[5]), .cluster6(cl[6]), .cluster7(cl[7]),
    .link_data(link_data), .link_k(link_k), .fifo_level(fifo_level),
    .overflow_cnt(overflow_cnt)
  );

  typedef struct { int due; logic [13:0] c; } sched_t;
  typedef struct { logic k; logic [15:0] d; int lvl; int ovf; } exp_t;

  logic [13:0] m_fifo [$];
  sched_t      sched [$];
  exp_t        exp_q [$];
  int          m_slot, m_frame, m_ovf, t;
  logic        m_pend;
  int          lvl0, acc, drops;
  logic        ek;
  logic [15:0] ed;

  // Reference model: each valid cluster is scheduled for the cycle its pair is scanned.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_fifo.delete(); sched.delete(); exp_q.delete();
      m_slot = 0; m_frame = 0; m_ovf = 0; m_pend = 1'b0; t = 0;
    end else begin
      lvl0 = m_fifo.size(); acc = 0; drops = 0;
      if (m_slot == 0) begin
        ek = 1'b1; ed = {8'hBC, m_pend, 7'(m_frame)};
        m_frame = (m_frame + 1) % 128;
      end else if (lvl0 > 0) begin
        ek = 1'b0; ed = {2'b01, m_fifo.pop_front()};
      end else begin
        ek = 1'b1; ed = 16'hF7F7;
      end
      while (sched.size() > 0 && sched[0].due == t) begin
        sched_t e;
        e = sched.pop_front();
        if (lvl0 + acc < DEPTH) begin m_fifo.push_back(e.c); acc++; end
        else drops++;
      end
      if (bx_strobe) begin
        drops += sched.size();
        sched.delete();
        for (int i = 0; i < 8; i++)
          if (int'(cl[i][10:0]) <= ADR_LIM) sched.push_back('{t + 1 + i / 2, cl[i]});
      end
      m_ovf  = (m_ovf + drops > 65535) ? 65535 : m_ovf + drops;
      m_pend = ((m_slot == 0) ? 1'b0 : m_pend) | (drops > 0);
      m_slot = (m_slot + 1) % 4;
      t++;
      exp_q.push_back('{ek, ed, m_fifo.size(), m_ovf});
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      checks++;
      if (link_data !== 16'h0 || link_k !== 1'b0 || fifo_level !== 5'd0 || overflow_cnt !== 16'h0) begin
        errors++;
        $display("FAIL reset_out: got k=%b d=%h lvl=%0d ovf=%0d, want all zero",
                 link_k, link_data, fifo_level, overflow_cnt);
      end
    end else if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (link_k !== e.k || link_data !== e.d || fifo_level !== 5'(e.lvl) || overflow_cnt !== 16'(e.ovf)) begin
        errors++;
        $display("FAIL link_word t=%0d: got k=%b d=%h lvl=%0d ovf=%0d, want k=%b d=%h lvl=%0d ovf=%0d",
                 t, link_k, link_data, fifo_level, overflow_cnt, e.k, e.d, e.lvl, e.ovf);
      end
    end
  end

  task automatic set_all(input logic [13:0] v);
    for (int i = 0; i < 8; i++) cl[i] = v;
  endtask

  task automatic strobe_once();
    bx_strobe = 1'b1;
    @(negedge clk);
    bx_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sustained(input int n);
    for (int s = 0; s < n; s++) begin
      set_all(14'h0100);
      for (int i = 0; i < 8; i++) cl[i] = 14'(i * 16 + s);
      strobe_once();
      idle(3);
    end
  endtask

  initial begin
    reset_n = 1'b0; bx_strobe = 1'b0; set_all(14'h07FE);
    idle(3);
    #2 reset_n = 1'b1;
    @(negedge clk);
    idle(520);                                    // frame_num wraps 127 -> 0

    set_all(14'h07FE); cl[3] = 14'h0123;          // single cluster
    strobe_once(); set_all(14'h07FE); idle(12);

    set_all(14'h07FE); cl[0] = 14'h0010; cl[5] = 14'h0020; cl[7] = 14'h0030;
    strobe_once(); set_all(14'h07FE); idle(12);

    set_all(14'h07FE); cl[0] = 14'h05FF; cl[1] = 14'h0600; cl[6] = 14'h3000;
    strobe_once(); set_all(14'h07FE); idle(12);   // address boundary

    max_lvl = 0;
    sustained(10);
    checks++;
    if (max_lvl != DEPTH) begin
      errors++;
      $display("FAIL fifo_full_level: got max=%0d, want %0d", max_lvl, DEPTH);
    end
    idle(40);                                     // drain, ovf flag clears

    for (int i = 0; i < 8; i++) cl[i] = 14'(14'h0200 + i);
    strobe_once(); idle(1);
    set_all(14'h07FF); strobe_once(); set_all(14'h07FE); idle(12);

    for (int c = 0; c < 400; c++) begin          // random traffic
      for (int i = 0; i < 8; i++) cl[i] = 14'($urandom_range(0, 16383));
      bx_strobe = ($urandom_range(0, 2) == 0);
      @(negedge clk);
    end
    bx_strobe = 1'b0; set_all(14'h07FE); idle(40);

    sustained(8);
    begin
      int n;
      n = 0;
      while (fifo_level != 5'd10 && n < 200) begin
        @(posedge clk); #2; n++;
      end
      checks++;
      if (fifo_level != 5'd10) begin
        errors++;
        $display("FAIL wait_level10: got lvl=%0d, want 10", fifo_level);
      end
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (link_data !== 16'h0 || link_k !== 1'b0 || fifo_level !== 5'd0 || overflow_cnt !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: got k=%b d=%h lvl=%0d ovf=%0d, want all zero",
               link_k, link_data, fifo_level, overflow_cnt);
    end
    @(negedge clk); idle(2);
    #2 reset_n = 1'b1;
    @(negedge clk);
    idle(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
